// File: rtl/i2c_reg_bank.sv
// i2c_reg_bank: register file behind the I2C slave.
// Writes land in a shadow copy (RW regs) or a clear mask (W1C regs) and are
// applied to the live registers in one step when the slave signals done.
// RO registers mirror ro_data; W1C flags are set by flag_set and drive irq.
module i2c_reg_bank #(
   parameter int                  ADDR_WIDTH = 8,
   parameter int                  DATA_WIDTH = 16,
   parameter int                  NUM_REGS   = 16,
   parameter logic [NUM_REGS-1:0] RO_MASK    = 16'h0003,
   parameter logic [NUM_REGS-1:0] W1C_MASK   = 16'h0004
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           i2c_write_en,
   input  logic [ADDR_WIDTH-1:0]          i2c_reg_addr,
   input  logic [DATA_WIDTH-1:0]          i2c_wdata,
   input  logic                           i2c_done,
   input  logic                           i2c_busy,
   output logic [DATA_WIDTH-1:0]          i2c_rdata,
   input  logic [NUM_REGS*DATA_WIDTH-1:0] ro_data,
   input  logic [NUM_REGS*DATA_WIDTH-1:0] flag_set,
   output logic [NUM_REGS*DATA_WIDTH-1:0] cfg_out,
   output logic                           cfg_update,
   output logic                           irq,
   output logic                           addr_err
);

   localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [ADDR_WIDTH-1:0] NUM_A = ADDR_WIDTH'(NUM_REGS);

   typedef logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_t;

   regs_t live_q, live_d;
   regs_t shadow_q, shadow_d;
   regs_t clr_q, clr_d;
   regs_t ro_arr, set_arr, cfg_arr;

   logic                  pend_q, pend_d;
   logic                  busy_q;
   logic                  upd_q, upd_d;
   logic                  irq_q, irq_d;
   logic                  err_q, err_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

   logic             start;
   logic             in_range;
   logic             commit;
   logic [IDX_W-1:0] idx;

   assign ro_arr  = ro_data;
   assign set_arr = flag_set;

   assign start    = i2c_busy & ~busy_q;
   assign in_range = (i2c_reg_addr < NUM_A);
   assign idx      = i2c_reg_addr[IDX_W-1:0];

   // Staging, commit and readback next-state. A write in the start cycle
   // lands on top of the fresh snapshot; a write in the done cycle is committed.
   always_comb begin
      shadow_d = start ? live_q : shadow_q;
      clr_d    = start ? '0 : clr_q;
      pend_d   = start ? 1'b0 : pend_q;
      err_d    = err_q;

      if (i2c_write_en) begin
         if (!in_range) begin
            err_d = 1'b1;
         end else if (!RO_MASK[idx]) begin
            pend_d = 1'b1;
            if (W1C_MASK[idx]) clr_d[idx] = clr_d[idx] | i2c_wdata;
            else               shadow_d[idx] = i2c_wdata;
         end
      end

      commit = i2c_done & pend_d;
      upd_d  = commit;

      live_d = live_q;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (W1C_MASK[i]) begin
            // set pulses are ORed after the clear so set wins in a commit cycle
            live_d[i] = (commit ? (live_q[i] & ~clr_d[i]) : live_q[i]) | set_arr[i];
         end else if (!RO_MASK[i] && commit) begin
            live_d[i] = shadow_d[i];
         end
      end

      if (commit) begin
         pend_d = 1'b0;
         clr_d  = '0;
      end

      irq_d = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (W1C_MASK[i]) irq_d = irq_d | (|live_d[i]);
      end

      // readback reflects committed state, never the shadow
      if (!in_range)         rdata_d = '0;
      else if (RO_MASK[idx]) rdata_d = ro_arr[idx];
      else                   rdata_d = live_q[idx];
   end

   // State registers with synchronous active-low reset; reset drops any staged writes.
   always_ff @(posedge clk) begin
      if (!reset) begin
         live_q   <= '0;
         shadow_q <= '0;
         clr_q    <= '0;
         pend_q   <= 1'b0;
         busy_q   <= 1'b0;
         upd_q    <= 1'b0;
         irq_q    <= 1'b0;
         err_q    <= 1'b0;
         rdata_q  <= '0;
      end else begin
         live_q   <= live_d;
         shadow_q <= shadow_d;
         clr_q    <= clr_d;
         pend_q   <= pend_d;
         busy_q   <= i2c_busy;
         upd_q    <= upd_d;
         irq_q    <= irq_d;
         err_q    <= err_d;
         rdata_q  <= rdata_d;
      end
   end

   // RO slices of cfg_out read zero; their values only appear on readback.
   for (genvar g = 0; g < NUM_REGS; g++) begin : g_cfg
      assign cfg_arr[g] = RO_MASK[g] ? '0 : live_q[g];
   end

   assign cfg_out    = cfg_arr;
   assign cfg_update = upd_q;
   assign irq        = irq_q;
   assign addr_err   = err_q;
   assign i2c_rdata  = rdata_q;

endmodule

// File: tb/tb_i2c_reg_bank.sv
// Bench for i2c_reg_bank: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction-level model.
module tb_i2c_reg_bank;

   localparam int NR = 16;
   localparam int DW = 16;
   localparam logic [NR-1:0] RO  = 16'h0003;
   localparam logic [NR-1:0] W1C = 16'h0004;

   logic           clk = 1'b0;
   logic           reset;
   logic           we, done, busy;
   logic [7:0]     addr;
   logic [DW-1:0]  wdata, rdata;
   logic [NR*DW-1:0] ro_data, flag_set, cfg_out;
   logic           cfg_update, irq, addr_err;

   i2c_reg_bank dut (
      .clk(clk), .reset(reset), .i2c_write_en(we), .i2c_reg_addr(addr),
      .i2c_wdata(wdata), .i2c_done(done), .i2c_busy(busy), .i2c_rdata(rdata),
      .ro_data(ro_data), .flag_set(flag_set), .cfg_out(cfg_out),
      .cfg_update(cfg_update), .irq(irq), .addr_err(addr_err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   // model: committed values, plus a map of staged writes per transaction
   logic [DW-1:0] m_live[NR];
   logic [DW-1:0] m_stg[NR];
   logic [DW-1:0] m_clr[NR];
   bit            m_has[NR];
   bit            m_pend, m_bprev, m_upd, m_irq, m_err;
   logic [DW-1:0] m_rd;

   task automatic chk(input string nm, input logic [NR*DW-1:0] act, input logic [NR*DW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic model_step();
      bit commit;
      int a;
      if (!reset) begin
         for (int i = 0; i < NR; i++) begin
            m_live[i] = '0; m_stg[i] = '0; m_clr[i] = '0; m_has[i] = 0;
         end
         m_pend = 0; m_bprev = 0; m_upd = 0; m_irq = 0; m_err = 0; m_rd = '0;
         return;
      end
      a = int'(addr);
      // readback uses values committed before this edge
      if (a >= NR)     m_rd = '0;
      else if (RO[a])  m_rd = ro_data[a*DW +: DW];
      else             m_rd = m_live[a];

      if (busy && !m_bprev) begin
         for (int i = 0; i < NR; i++) begin m_has[i] = 0; m_clr[i] = '0; end
         m_pend = 0;
      end
      m_bprev = busy;

      if (we) begin
         if (a >= NR) m_err = 1;
         else if (RO[a]) ;
         else if (W1C[a]) begin m_clr[a] |= wdata; m_pend = 1; end
         else begin m_stg[a] = wdata; m_has[a] = 1; m_pend = 1; end
      end

      commit = done && m_pend;
      m_upd = commit;
      for (int i = 0; i < NR; i++) begin
         if (W1C[i])
            m_live[i] = (commit ? (m_live[i] & ~m_clr[i]) : m_live[i]) | flag_set[i*DW +: DW];
         else if (commit && m_has[i])
            m_live[i] = m_stg[i];
      end
      if (commit) begin
         for (int i = 0; i < NR; i++) begin m_has[i] = 0; m_clr[i] = '0; end
         m_pend = 0;
      end
      m_irq = 0;
      for (int i = 0; i < NR; i++) if (W1C[i] && m_live[i] != 0) m_irq = 1;
   endtask

   // one clock: DUT and model both consume the inputs held across this edge
   task automatic cyc();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic clr_strobes();
      we = 0; done = 0; flag_set = '0;
   endtask

   task automatic txn_start();
      busy = 0; cyc(); busy = 1; cyc();
   endtask

   // every-cycle comparison of all outputs against the model
   always @(negedge clk) begin
      logic [NR*DW-1:0] exp_cfg;
      if (chk_en) begin
         for (int i = 0; i < NR; i++) exp_cfg[i*DW +: DW] = RO[i] ? '0 : m_live[i];
         chk("m_cfg_out", cfg_out, exp_cfg);
         chk("m_rdata", {{(NR*DW-DW){1'b0}}, rdata}, {{(NR*DW-DW){1'b0}}, m_rd});
         chk("m_cfg_update", {{(NR*DW-1){1'b0}}, cfg_update}, {{(NR*DW-1){1'b0}}, m_upd});
         chk("m_irq", {{(NR*DW-1){1'b0}}, irq}, {{(NR*DW-1){1'b0}}, m_irq});
         chk("m_addr_err", {{(NR*DW-1){1'b0}}, addr_err}, {{(NR*DW-1){1'b0}}, m_err});
      end
   end

   initial begin
      reset = 0; busy = 0; we = 0; addr = '0; wdata = '0; done = 0;
      ro_data = '0; flag_set = '0;
      cyc(); chk_en = 1'b1; cyc();
      @(negedge clk);
      chk("rst_cfg_out", cfg_out, '0);
      chk("rst_flags", {cfg_update, irq, addr_err}, '0);
      chk("rst_rdata", rdata, '0);
      reset = 1;

      // staged write stays invisible until done, then one update pulse
      txn_start();
      we = 1; addr = 8'd5; wdata = 16'h1234; cyc(); we = 0; cyc();
      @(negedge clk); chk("s1_hold", cfg_out[5*DW +: DW], '0);
      done = 1; cyc(); done = 0;
      @(negedge clk);
      chk("s1_commit", cfg_out[5*DW +: DW], 16'h1234);
      chk("s1_upd", cfg_update, 1);
      cyc(); @(negedge clk); chk("s1_upd_pulse", cfg_update, 0);

      // burst of two writes commits together
      txn_start();
      we = 1; addr = 8'd3; wdata = 16'hAAAA; cyc();
      addr = 8'd4; wdata = 16'h5555; cyc(); we = 0;
      @(negedge clk); chk("s2_hold", cfg_out[4*DW +: DW], '0);
      done = 1; cyc(); done = 0;
      @(negedge clk);
      chk("s2_pair", {cfg_out[4*DW +: DW], cfg_out[3*DW +: DW]}, 32'h5555AAAA);
      chk("s2_upd", cfg_update, 1);

      // W1C: set raises irq, write-1 + done clears, set in commit cycle wins
      flag_set[2*DW] = 1; cyc(); clr_strobes();
      @(negedge clk); chk("s3_irq_set", irq, 1); chk("s3_flag", cfg_out[2*DW +: DW], 16'h0001);
      txn_start();
      we = 1; addr = 8'd2; wdata = 16'h0001; done = 1; cyc(); clr_strobes();
      @(negedge clk); chk("s3_cleared", cfg_out[2*DW +: DW], '0); chk("s3_irq_clr", irq, 0);
      flag_set[2*DW] = 1; cyc(); clr_strobes();
      txn_start();
      we = 1; addr = 8'd2; wdata = 16'h0001; done = 1; flag_set[2*DW] = 1; cyc(); clr_strobes();
      @(negedge clk); chk("s3_set_wins", cfg_out[2*DW +: DW], 16'h0001); chk("s3_irq_hold", irq, 1);

      // RO write is ignored; readback comes from ro_data
      ro_data[15:0] = 16'hA5A5;
      txn_start();
      we = 1; addr = 8'd0; wdata = 16'hFFFF; done = 1; cyc(); clr_strobes();
      @(negedge clk);
      chk("s4_no_upd", cfg_update, 0);
      chk("s4_rdata", rdata, 16'hA5A5);
      chk("s4_cfg0", cfg_out[15:0], '0);

      // out-of-range write: sticky error, reads zero, nothing committed
      txn_start();
      we = 1; addr = 8'h20; wdata = 16'hFFFF; cyc(); we = 0;
      @(negedge clk); chk("s5_err", addr_err, 1); chk("s5_rdata", rdata, '0);
      done = 1; cyc(); done = 0;
      @(negedge clk); chk("s5_no_upd", cfg_update, 0);
      cyc(); cyc();
      @(negedge clk); chk("s5_sticky", addr_err, 1);

      // reset mid-transaction discards staged data
      txn_start();
      we = 1; addr = 8'd6; wdata = 16'h6666; cyc(); we = 0;
      reset = 0; cyc(); reset = 1; busy = 0; cyc();
      @(negedge clk);
      chk("s6_reg6", cfg_out[6*DW +: DW], '0);
      chk("s6_err_rst", addr_err, 0);
      txn_start();
      we = 1; addr = 8'd7; wdata = 16'h0777; done = 1; cyc(); clr_strobes();
      @(negedge clk);
      chk("s6_pair", {cfg_out[7*DW +: DW], cfg_out[6*DW +: DW]}, 32'h07770000);
      chk("s6_upd", cfg_update, 1);

      // randomized traffic, model checked every cycle
      for (int k = 0; k < 4000; k++) begin
         reset = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
         if ($urandom_range(0, 9) == 0) busy = ~busy;
         we    = busy && ($urandom_range(0, 2) == 0);
         addr  = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(16, 255)) : 8'($urandom_range(0, 15));
         wdata = 16'($urandom);
         done  = busy && ($urandom_range(0, 5) == 0);
         flag_set = '0;
         if ($urandom_range(0, 5) == 0) flag_set[2*DW + $urandom_range(0, 15)] = 1'b1;
         if ($urandom_range(0, 9) == 0) flag_set[$urandom_range(0, NR*DW-1)] = 1'b1;
         if ($urandom_range(0, 15) == 0)
            for (int i = 0; i < NR; i++) ro_data[i*DW +: DW] = 16'($urandom);
         cyc();
      end
      clr_strobes();
      cyc();
      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
